// File: rtl/sprite_line_fetch_pkg.sv
// Shared constants, FSM encoding and slot record for the per-scanline sprite prefetch stage.
package sprite_line_fetch_pkg;

  localparam int MAX_SPRITES  = 2;
  localparam int OBJ_BYTES    = 4;
  localparam int BITMAP_BASE  = OBJ_BYTES * MAX_SPRITES;
  localparam int BITMAP_BYTES = 55;

  // Byte offsets of the fields inside one object entry
  localparam logic [1:0] FLD_X    = 2'd0;
  localparam logic [1:0] FLD_Y    = 2'd1;
  localparam logic [1:0] FLD_OFF  = 2'd2;
  localparam logic [1:0] FLD_SIZE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OBJ_RD = 3'd1,
    S_CHECK  = 3'd2,
    S_BMP_RD = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [7:0]  x;
    logic [4:0]  width;
    logic [15:0] row_mask;
  } slot_t;

  // Ones in bit positions below width (width 1..16)
  function automatic logic [15:0] width_mask(input logic [4:0] width);
    return 16'((17'd1 << width) - 17'd1);
  endfunction

endpackage

// File: rtl/sprite_row_slot.sv
// One sprite slot: shadow row built during hblank, live row used for the pixel hit test.
module sprite_row_slot
  import sprite_line_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  slot_t      load_data,
  input  logic       swap,
  input  logic       clear,
  input  logic [7:0] lx,
  output logic       hit
);

  slot_t      shadow_q;
  slot_t      live_q;
  logic [8:0] x_end;
  logic [3:0] col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      live_q   <= '0;
    end else begin
      if (load) shadow_q <= load_data;
      if (clear)     live_q <= '0;
      else if (swap) live_q <= shadow_q;
    end
  end

  // 9-bit end bound so sprites near x=255 clip instead of wrapping to column 0
  always_comb begin
    x_end = {1'b0, live_q.x} + {4'b0, live_q.width};
    col   = lx[3:0] - live_q.x[3:0];
    hit   = live_q.valid && (lx >= live_q.x) && ({1'b0, lx} < x_end) && live_q.row_mask[col];
  end

endmodule

// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite prefetch: walks the object table and bitmap through one byte read port,
// builds shadow row masks during hblank and swaps them live at the visible rise.
module sprite_line_fetch
  import sprite_line_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_start,
  input  logic [9:0] next_y,
  input  logic       visible,
  input  logic [9:0] pix_x,
  output logic       mem_rd_en,
  output logic [5:0] mem_rd_addr,
  input  logic [7:0] mem_rd_data,
  output logic       pix_hit,
  output logic       busy,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic [2:0] dbg_state
);

  localparam int IDX_W = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;

  fetch_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       byte_idx_q;
  logic             phase_q;
  logic [7:0]       ly_q, obj_x_q, obj_y_q, obj_off_q, obj_size_q;
  logic [23:0]      asm_q;
  logic             cover_q, visible_q;

  logic vis_rise, fetching, restart, abort, stay, last_sprite, swap;
  logic [MAX_SPRITES-1:0] slot_load, slot_hit;
  slot_t                  load_data;

  logic [4:0] width, height, span;
  logic [8:0] y_end, byte_base, cur_byte;
  logic [7:0] row, bit_offset;
  logic [2:0] start_bit;
  logic       covers, byte_last, in_range;
  logic [5:0] obj_addr, bmp_addr;
  logic [15:0] shifted;
  logic       unused_ok;

  assign vis_rise    = visible & ~visible_q;
  assign fetching    = (state_q == S_OBJ_RD) || (state_q == S_CHECK) ||
                       (state_q == S_BMP_RD) || (state_q == S_NEXT);
  assign restart     = line_start && (state_q != S_IDLE);
  assign abort       = vis_rise && fetching;
  assign last_sprite = (idx_q == IDX_W'(MAX_SPRITES - 1));
  assign stay        = (state_d == state_q) && !restart;
  assign busy        = fetching;
  assign dbg_state   = state_q;
  assign unused_ok   = ^{next_y[1:0], pix_x[1:0]};

  // Geometry of the object currently held in obj_*_q against the line being prepared
  always_comb begin
    width      = {1'b0, obj_size_q[7:4]} + 5'd1;
    height     = {1'b0, obj_size_q[3:0]} + 5'd1;
    y_end      = {1'b0, obj_y_q} + {4'b0, height};
    covers     = (ly_q >= obj_y_q) && ({1'b0, ly_q} < y_end);
    row        = ly_q - obj_y_q;
    bit_offset = row * {3'b0, width};
    start_bit  = bit_offset[2:0];
    byte_base  = {1'b0, obj_off_q} + {4'b0, bit_offset[7:3]};
    cur_byte   = byte_base + {7'b0, byte_idx_q};
    in_range   = cur_byte < 9'(BITMAP_BYTES);
    span       = {2'b0, start_bit} + width;
    byte_last  = ({1'b0, byte_idx_q, 3'b000} + 6'd8) >= {1'b0, span};
    obj_addr   = 6'(idx_q) * 6'(OBJ_BYTES) + {4'b0, byte_idx_q};
    bmp_addr   = 6'(BITMAP_BASE) + cur_byte[5:0];
    shifted    = 16'(asm_q >> start_bit);
  end

  always_comb begin
    load_data.valid    = cover_q;
    load_data.x        = obj_x_q;
    load_data.width    = width;
    load_data.row_mask = cover_q ? (shifted & width_mask(width)) : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A new line_start always wins: it restarts the walk even over a visible-rise abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (line_start) state_d = S_OBJ_RD;
      S_OBJ_RD: if (phase_q && byte_idx_q == FLD_SIZE) state_d = S_CHECK;
      S_CHECK:  state_d = covers ? S_BMP_RD : S_NEXT;
      S_BMP_RD: if (phase_q && byte_last) state_d = S_NEXT;
      S_NEXT:   state_d = last_sprite ? S_DONE : S_OBJ_RD;
      S_DONE:   if (vis_rise) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort)   state_d = S_IDLE;
    if (restart) state_d = S_OBJ_RD;
  end

  // Read port: mem_rd_en is a one-cycle strobe (phase 0) and mem_rd_data is captured the
  // following cycle (phase 1); only one read is ever outstanding.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    slot_load   = '0;
    swap        = 1'b0;
    case (state_q)
      S_OBJ_RD: begin
        mem_rd_en   = !phase_q;
        mem_rd_addr = obj_addr;
      end
      S_BMP_RD: begin
        mem_rd_en   = !phase_q && in_range;
        mem_rd_addr = bmp_addr;
      end
      S_NEXT:  slot_load[idx_q] = 1'b1;
      S_DONE:  swap = vis_rise && !line_start;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      byte_idx_q <= '0;
      phase_q    <= 1'b0;
      ly_q       <= '0;
      obj_x_q    <= '0;
      obj_y_q    <= '0;
      obj_off_q  <= '0;
      obj_size_q <= '0;
      asm_q      <= '0;
      cover_q    <= 1'b0;
      visible_q  <= 1'b0;
      overrun    <= 1'b0;
      pix_hit    <= 1'b0;
    end else begin
      visible_q <= visible;
      if (line_start) ly_q <= next_y[9:2];
      if (stay && (state_q == S_OBJ_RD || state_q == S_BMP_RD)) begin
        phase_q <= ~phase_q;
        if (phase_q) byte_idx_q <= byte_idx_q + 2'd1;
      end else begin
        phase_q    <= 1'b0;
        byte_idx_q <= '0;
      end
      if (line_start) idx_q <= '0;
      else if (state_q == S_NEXT && state_d == S_OBJ_RD) idx_q <= idx_q + IDX_W'(1);
      if (state_q == S_OBJ_RD && phase_q) begin
        case (byte_idx_q)
          FLD_X:    obj_x_q    <= mem_rd_data;
          FLD_Y:    obj_y_q    <= mem_rd_data;
          FLD_OFF:  obj_off_q  <= mem_rd_data;
          FLD_SIZE: obj_size_q <= mem_rd_data;
        endcase
      end
      // Skipped out-of-range bytes stay 0 because the assembly register is cleared in CHECK
      if (state_q == S_CHECK) begin
        cover_q <= covers;
        asm_q   <= '0;
      end else if (state_q == S_BMP_RD && phase_q && in_range) begin
        case (byte_idx_q)
          2'd0:    asm_q[7:0]   <= mem_rd_data;
          2'd1:    asm_q[15:8]  <= mem_rd_data;
          default: asm_q[23:16] <= mem_rd_data;
        endcase
      end
      overrun <= abort | restart | (overrun & ~overrun_clr);
      pix_hit <= visible & (|slot_hit);
    end
  end

  for (genvar i = 0; i < MAX_SPRITES; i++) begin : g_slot
    sprite_row_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load[i]),
      .load_data (load_data),
      .swap      (swap),
      .clear     (abort),
      .lx        (pix_x[9:2]),
      .hit       (slot_hit[i])
    );
  end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch: byte RAM model, read-address and pix_hit scoreboards.
module tb_sprite_line_fetch;
  import sprite_line_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] next_y = '0;
  logic       visible = 1'b0;
  logic [9:0] pix_x = '0;
  logic       mem_rd_en;
  logic [5:0] mem_rd_addr;
  logic [7:0] mem_rd_data = '0;
  logic       pix_hit, busy, overrun;
  logic       overrun_clr = 1'b0;
  logic [2:0] dbg_state;

  logic [7:0] mem [0:63];
  logic [5:0] exp_addr_q[$];
  logic [8:0] exp_hit_q[$];
  logic       exp_line [0:255];
  logic       addr_chk = 1'b0;
  logic       chk_arm = 1'b0;
  logic       chk_d = 1'b0;
  logic [8:0] hit_item;
  logic [5:0] addr_item;
  logic [15:0] m;
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  sprite_line_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_start  (line_start),
    .next_y      (next_y),
    .visible     (visible),
    .pix_x       (pix_x),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .pix_hit     (pix_hit),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .dbg_state   (dbg_state)
  );

  // Byte RAM: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    chk_d <= chk_arm;
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (mem_rd_en) begin
      checks++;
      if (mem_rd_addr > 6'd62) begin
        errors++;
        $display("FAIL rd_addr_range: got %0d expected <= 62", mem_rd_addr);
      end
      if (addr_chk) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL rd_addr_seq: got read at %0d expected no read", mem_rd_addr);
        end else begin
          addr_item = exp_addr_q.pop_front();
          if (mem_rd_addr !== addr_item) begin
            errors++;
            $display("FAIL rd_addr_seq: got %0d expected %0d", mem_rd_addr, addr_item);
          end
        end
      end
    end
    if (chk_d) begin
      checks++;
      if (exp_hit_q.size() == 0) begin
        errors++;
        $display("FAIL pix_hit: got %b with no expected value queued", pix_hit);
      end else begin
        hit_item = exp_hit_q.pop_front();
        if (pix_hit !== hit_item[0]) begin
          errors++;
          $display("FAIL pix_hit lx=%0d: got %b expected %b", hit_item[8:1], pix_hit, hit_item[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_obj(input int i, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] off, input logic [7:0] size);
    mem[i*4+0] = x;
    mem[i*4+1] = y;
    mem[i*4+2] = off;
    mem[i*4+3] = size;
  endtask

  task automatic push_obj_reads(input int i);
    for (int b = 0; b < 4; b++) exp_addr_q.push_back(6'(i*4 + b));
  endtask

  task automatic clear_exp;
    for (int i = 0; i < 256; i++) exp_line[i] = 1'b0;
  endtask

  task automatic start_line(input logic [9:0] y);
    next_y = y;
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (dbg_state !== s && n < budget) begin
      tick;
      n++;
    end
    check(name, dbg_state, s);
  endtask

  // First visible cycle performs the swap and is not scored; lx 0..255 follow
  task automatic scan_line(input string name);
    visible = 1'b1;
    pix_x = '0;
    tick;
    chk_arm = 1'b1;
    for (int lx = 0; lx < 256; lx++) begin
      pix_x = 10'(lx * 4);
      exp_hit_q.push_back({8'(lx), exp_line[lx]});
      tick;
    end
    chk_arm = 1'b0;
    tick;
    visible = 1'b0;
    pix_x = '0;
    tick;
    tick;
    check({name, " hit_q drained"}, exp_hit_q.size(), 0);
  endtask

  task automatic run_line(input logic [9:0] y, input string name);
    start_line(y);
    wait_state(S_DONE, 200, {name, " reach DONE"});
    scan_line(name);
    check({name, " reads drained"}, exp_addr_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    set_obj(1, 8'd0, 8'd200, 8'd0, 8'h00);   // sprite 1 parked off these lines

    tick;
    tick;
    check("reset pix_hit", pix_hit, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    check("reset mem_rd_en", mem_rd_en, 0);
    check("reset state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    tick;

    // 8x8 sprite, row 0 byte 0x81 -> lx 10 and 17
    set_obj(0, 8'd10, 8'd5, 8'd0, 8'h77);
    mem[8] = 8'h81;
    clear_exp;
    exp_line[10] = 1'b1;
    exp_line[17] = 1'b1;
    push_obj_reads(0); exp_addr_q.push_back(6'd8); push_obj_reads(1);
    addr_chk = 1'b1;
    run_line(10'd20, "t1a");
    check("t1a overrun", overrun, 0);

    // Same sprite at y=0: ly 5 is row 5, bitmap byte 5
    mem[8] = 8'h00;
    mem[13] = 8'h81;
    set_obj(0, 8'd10, 8'd0, 8'd0, 8'h77);
    push_obj_reads(0); exp_addr_q.push_back(6'd13); push_obj_reads(1);
    run_line(10'd20, "t1b");

    // Width 12: two bytes, mask 0x0DAB
    mem[13] = 8'h00;
    mem[8] = 8'hAB; mem[9] = 8'hCD; mem[10] = 8'hEF;
    set_obj(0, 8'd20, 8'd10, 8'd0, 8'hB0);
    clear_exp;
    m = 16'h0DAB;
    for (int b = 0; b < 16; b++) if (m[b]) exp_line[20+b] = 1'b1;
    push_obj_reads(0); exp_addr_q.push_back(6'd8); exp_addr_q.push_back(6'd9); push_obj_reads(1);
    run_line(10'd40, "t2");

    // Right-edge clip: lx 250..255 on, no wrap into 0..9
    mem[28] = 8'hFF; mem[29] = 8'hFF;
    set_obj(0, 8'd250, 8'd10, 8'd20, 8'hF0);
    clear_exp;
    for (int i = 250; i < 256; i++) exp_line[i] = 1'b1;
    push_obj_reads(0); exp_addr_q.push_back(6'd28); exp_addr_q.push_back(6'd29); push_obj_reads(1);
    run_line(10'd40, "t3");

    // Bitmap end: only address 62 is read, upper mask byte zero
    mem[62] = 8'hFF; mem[63] = 8'hFF;
    set_obj(0, 8'd100, 8'd10, 8'd54, 8'hF0);
    clear_exp;
    for (int i = 100; i < 108; i++) exp_line[i] = 1'b1;
    push_obj_reads(0); exp_addr_q.push_back(6'd62); push_obj_reads(1);
    run_line(10'd40, "t4");

    // Overrun A: visible rises 10 cycles after line_start with two covering sprites
    set_obj(0, 8'd20, 8'd10, 8'd0, 8'hB0);
    set_obj(1, 8'd60, 8'd10, 8'd3, 8'h70);
    mem[11] = 8'h3C;
    addr_chk = 1'b0;
    clear_exp;
    start_line(10'd40);
    repeat (9) tick;
    scan_line("t5 aborted line");
    check("t5 overrun set", overrun, 1);

    addr_chk = 1'b1;
    clear_exp;
    m = 16'h0DAB;
    for (int b = 0; b < 16; b++) if (m[b]) exp_line[20+b] = 1'b1;
    for (int i = 62; i < 66; i++) exp_line[i] = 1'b1;
    push_obj_reads(0); exp_addr_q.push_back(6'd8); exp_addr_q.push_back(6'd9);
    push_obj_reads(1); exp_addr_q.push_back(6'd11);
    run_line(10'd40, "t5 next line");
    check("t5 overrun sticky", overrun, 1);
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    check("t5 overrun cleared", overrun, 0);

    // Overrun B during BMP_RD, then async reset mid-fetch
    addr_chk = 1'b0;
    visible = 1'b1;
    pix_x = 10'd80;
    tick;
    tick;
    start_line(10'd40);
    wait_state(S_BMP_RD, 40, "t6 reach BMP_RD");
    start_line(10'd40);
    check("t6 overrun set", overrun, 1);
    check("t6 restart rd_en", mem_rd_en, 1);
    check("t6 restart addr", mem_rd_addr, 0);
    tick;
    tick;
    tick;
    check("t6 live hit during fetch", pix_hit, 1);
    check("t6 busy during fetch", busy, 1);
    rst_n = 1'b0;
    #2;
    check("t6 async busy", busy, 0);
    check("t6 async pix_hit", pix_hit, 0);
    check("t6 async mem_rd_en", mem_rd_en, 0);
    check("t6 async overrun", overrun, 0);
    visible = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
